strobe_capture_fifo: RTL and testbench

- Parametrised successor to the single-bit derived-clock capture flop.
- Request lines are combined per mode into a trigger. A synchronous rising-edge detect on the trigger replaces the derived clock.
- Each edge captures a DATA_W-bit word into a DEPTH-entry FIFO, drained through a valid/ready interface.
- Sits between asynchronous-style event sources and single-clock-domain consumers.

---
 rtl/strobe_capture_pkg.sv | 11 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/strobe_capture_fifo.sv | 102 ++++++++++
 tb/tb_strobe_capture_fifo.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_capture_pkg.sv
// Shared definitions for the strobe capture FIFO: trigger combine modes.
package strobe_capture_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ALL0 = 2'b00;  // any request line
    localparam mode_t MODE_ALL1 = 2'b01;  // any request line
    localparam mode_t MODE_OFF  = 2'b10;  // capture disabled
    localparam mode_t MODE_HIGH = 2'b11;  // upper half of request lines only

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with drop-on-full. A push that arrives while full is
// accepted only if a pop frees a slot in the same cycle; otherwise it is
// discarded and reported on the combinational drop pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             drop
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    // While empty, the output keeps the last head shown rather than a stale slot.
    assign rd_data = valid ? mem[rd_ptr] : last_head;

    // Storage, pointers and occupancy; reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            last_head <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (valid) last_head <= mem[rd_ptr];
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/strobe_capture_fifo.sv
// Strobe capture FIFO: request lines are combined into a trigger, a rising
// edge of the trigger captures din into a FIFO drained by valid/ready.
// Optional macro STROBE_CAPTURE_TIMESTAMP_EN adds a free-running stamp
// counter stored with each word and presented on out_ts.
module strobe_capture_fifo
    import strobe_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREQ   = 4,
    parameter int DEPTH  = 4,
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
    parameter int TS_W   = 16,
`endif
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  mode_t             mode,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
    output logic [TS_W-1:0]   out_ts,
`endif
    output logic [CW-1:0]     count,
    output logic              overflow
);

`ifdef STROBE_CAPTURE_TIMESTAMP_EN
    localparam int FW = DATA_W + TS_W;
    logic [TS_W-1:0] ts;
`else
    localparam int FW = DATA_W;
`endif

    logic          trig;
    logic          trig_q;
    logic          fire;
    logic          drop;
    logic          full;
    logic [FW-1:0] wr_word;
    logic [FW-1:0] rd_word;

    // Combine request lines according to the current mode.
    always_comb begin
        trig = 1'b0;
        case (mode)
            MODE_ALL0, MODE_ALL1: trig = |req;
            MODE_HIGH:            trig = |req[NREQ-1:NREQ/2];
            default:              trig = 1'b0;
        endcase
    end

    // Previous trigger; resets high so a trigger already asserted at reset
    // release needs a fresh low->high transition before it captures.
    always_ff @(posedge clk) begin
        if (reset) trig_q <= 1'b1;
        else       trig_q <= trig;
    end

    assign fire = trig & ~trig_q;

    // Sticky record of any dropped capture.
    always_ff @(posedge clk) begin
        if (reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef STROBE_CAPTURE_TIMESTAMP_EN
    // Free-running stamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else       ts <= ts + TS_W'(1);
    end

    assign wr_word  = {ts, din};
    assign out_data = rd_word[DATA_W-1:0];
    assign out_ts   = rd_word[FW-1:DATA_W];
`else
    assign wr_word  = din;
    assign out_data = rd_word;
`endif

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fire),
        .pop     (out_ready),
        .wr_data (wr_word),
        .rd_data (rd_word),
        .valid   (out_valid),
        .full    (full),
        .count   (count),
        .drop    (drop)
    );

endmodule

// File: tb/tb_strobe_capture_fifo.sv
// Self-checking bench for strobe_capture_fifo with a data scoreboard.
module tb_strobe_capture_fifo;

    localparam int DATA_W = 8;
    localparam int NREQ   = 4;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [1:0]        mode = 2'b00;
    logic [DATA_W-1:0] din = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     count;
    logic              overflow;
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
    logic [15:0]       out_ts;
    logic [15:0]       ts_m;
    logic [15:0]       ts_q[$];
`endif

    logic [DATA_W-1:0] sb[$];
    int tests_run = 0;
    int tests_failed = 0;

    strobe_capture_fifo #(.DATA_W(DATA_W), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

`ifdef STROBE_CAPTURE_TIMESTAMP_EN
    always @(posedge clk) begin
        if (reset) ts_m <= '0;
        else       ts_m <= ts_m + 16'd1;
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Low cycle then one high cycle on req[0] in mode 00: one fresh edge.
    // The scoreboard records the word if the bench expects it to fit.
    task automatic strobe(input logic [DATA_W-1:0] d);
        req = '0;
        tick();
        req = 4'b0001;
        din = d;
        if (sb.size() < DEPTH) begin
            sb.push_back(d);
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
            ts_q.push_back(ts_m);
`endif
        end
        tick();
        req = '0;
    endtask

    // Pop every scoreboard entry, checking order and final emptiness.
    task automatic drain(input string name);
        logic [DATA_W-1:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests_run++;
            if (out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s valid: got %b want 1", name, out_valid);
            end
            tests_run++;
            if (out_data !== e) begin
                tests_failed++;
                $display("FAIL %s data: got %h want %h", name, out_data, e);
            end
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
            begin
                logic [15:0] t;
                t = ts_q.pop_front();
                tests_run++;
                if (out_ts !== t) begin
                    tests_failed++;
                    $display("FAIL %s ts: got %0d want %0d", name, out_ts, t);
                end
            end
`endif
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s empty: got valid=%b want 0", name, out_valid);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        mode = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        ts_q.delete();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b0001;
        mode = 2'b00;
        tick();
        tick();
        tests_run++;
        if (count !== 0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: got cnt=%0d v=%b ov=%b d=%h want 0 0 0 00",
                     count, out_valid, overflow, out_data);
        end
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (count !== 0) begin
            tests_failed++;
            $display("FAIL held_req_no_fire: got count=%0d want 0", count);
        end
        req = '0;
        tick();
        req = 4'b0001;
        din = 8'hA5;
        sb.push_back(8'hA5);
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        ts_q.push_back(ts_m);
`endif
        tick();
        req = '0;
        tests_run++;
        if (count !== 1) begin
            tests_failed++;
            $display("FAIL first_capture count: got %0d want 1", count);
        end
        drain("first_capture");
    endtask

    task automatic test_modes();
        mode = 2'b11;
        req = '0;
        tick();
        req = 4'b0011;
        tick();
        req = '0;
        tick();
        tests_run++;
        if (count !== 0) begin
            tests_failed++;
            $display("FAIL mode11_low_half: got count=%0d want 0", count);
        end
        req = 4'b0100;
        din = 8'h3C;
        sb.push_back(8'h3C);
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        ts_q.push_back(ts_m);
`endif
        tick();
        req = '0;
        tick();
        tests_run++;
        if (count !== 1) begin
            tests_failed++;
            $display("FAIL mode11_high_half: got count=%0d want 1", count);
        end
        drain("mode11");
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            req = (i % 2 == 1) ? 4'b1111 : 4'b0000;
            tick();
        end
        req = '0;
        tick();
        tests_run++;
        if (count !== 0) begin
            tests_failed++;
            $display("FAIL mode10_disabled: got count=%0d want 0", count);
        end
        mode = 2'b00;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) strobe(DATA_W'(i));
        tick();
        tests_run++;
        if (count !== 4 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_fill: got cnt=%0d ov=%b want 4 1", count, overflow);
        end
        drain("overflow_drain");
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) strobe(8'h10 + DATA_W'(i));
        tick();
        tests_run++;
        if (out_data !== sb[0]) begin
            tests_failed++;
            $display("FAIL full_pop head: got %h want %h", out_data, sb[0]);
        end
        void'(sb.pop_front());
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        void'(ts_q.pop_front());
        ts_q.push_back(ts_m);
`endif
        sb.push_back(8'h77);
        req = 4'b0001;
        din = 8'h77;
        out_ready = 1'b1;
        tick();
        req = '0;
        out_ready = 1'b0;
        tests_run++;
        if (count !== 4 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_push_pop: got cnt=%0d ov=%b want 4 0", count, overflow);
        end
        drain("full_push_pop");
    endtask

    task automatic test_held_and_midreset();
        do_reset();
        req = '0;
        tick();
        req = 4'b0001;
        din = 8'h5A;
        sb.push_back(8'h5A);
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        ts_q.push_back(ts_m);
`endif
        for (int i = 0; i < 10; i++) begin
            tick();
            din = din + 8'd1;
        end
        req = '0;
        tick();
        tests_run++;
        if (count !== 1) begin
            tests_failed++;
            $display("FAIL held_one_capture: got count=%0d want 1", count);
        end
        strobe(8'hC1);
        strobe(8'hC2);
        tests_run++;
        if (count !== 3) begin
            tests_failed++;
            $display("FAIL pre_reset count: got %0d want 3", count);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (count !== 0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: got cnt=%0d v=%b ov=%b d=%h want 0 0 0 00",
                     count, out_valid, overflow, out_data);
        end
        reset = 1'b0;
        sb.delete();
`ifdef STROBE_CAPTURE_TIMESTAMP_EN
        ts_q.delete();
`endif
    endtask

    initial begin
        test_reset();
        test_modes();
        test_overflow();
        test_full_push_pop();
        test_held_and_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
